turn_signal_seq: RTL and testbench

// - Sequences the three-lamp left/right turn-signal pattern from driver switch inputs.
// - Emits a 3-bit mode code to the seven-segment decoder: 000 '0' idle, 001 'L', 011 'R'.
// - Emits only these three codes; never drives 010, 100, 101 or 110.
// - Sits between the board switches and the decoder/lamp pins; a single clock domain.

---
 rtl/turn_signal_seq_if.sv | 21 ++
 rtl/turn_signal_seq.sv | 160 ++++++++++++++++
 tb/tb_turn_signal_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/turn_signal_seq_if.sv
// Switch inputs and lamp/decoder outputs of the turn-signal sequencer, bundled as one port.
// The board/testbench drives the master side and the sequencer takes the slave side.
interface turn_signal_seq_if;
    logic       left_sw;
    logic       right_sw;
    logic       hazard_sw;
    logic [2:0] seg_code;
    logic [2:0] left_lamps;
    logic [2:0] right_lamps;
    logic       busy;

    modport master (
        output left_sw, right_sw, hazard_sw,
        input  seg_code, left_lamps, right_lamps, busy
    );

    modport slave (
        input  left_sw, right_sw, hazard_sw,
        output seg_code, left_lamps, right_lamps, busy
    );
endinterface

// File: rtl/turn_signal_seq.sv
// Three-lamp left/right turn-signal sequencer with a seven-segment mode code.
// Define HAZARD_EN to add the hazard flasher (HZ_ON/HZ_OFF states).
module turn_signal_seq #(
    parameter  int TICK_DIV = 25_000_000,
    localparam int CNT_W    = $clog2(TICK_DIV)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    turn_signal_seq_if.slave     sig
);

`ifdef HAZARD_EN
    typedef enum logic [3:0] {
        IDLE, L1, L2, L3, R1, R2, R3, HZ_ON, HZ_OFF
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, L1, L2, L3, R1, R2, R3
    } state_t;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       seg_code_q, seg_code_d;
    logic [2:0]       left_lamps_q, left_lamps_d;
    logic [2:0]       right_lamps_q, right_lamps_d;
    logic             busy_q, busy_d;

    logic left_meta_q, left_sync_q;
    logic right_meta_q, right_sync_q;
    logic hz;
    logic req_l, req_r, any_req, tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_meta_q  <= 1'b0;
            left_sync_q  <= 1'b0;
            right_meta_q <= 1'b0;
            right_sync_q <= 1'b0;
        end else begin
            left_meta_q  <= sig.left_sw;
            left_sync_q  <= left_meta_q;
            right_meta_q <= sig.right_sw;
            right_sync_q <= right_meta_q;
        end
    end

`ifdef HAZARD_EN
    logic hazard_meta_q, hazard_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hazard_meta_q <= 1'b0;
            hazard_sync_q <= 1'b0;
        end else begin
            hazard_meta_q <= sig.hazard_sw;
            hazard_sync_q <= hazard_meta_q;
        end
    end

    assign hz = hazard_sync_q;
`else
    logic unused_hazard;
    assign unused_hazard = sig.hazard_sw;
    assign hz = 1'b0;
`endif

    // Both directions at once cancel each other; hazard outranks either direction.
    assign req_l   = left_sync_q & ~right_sync_q;
    assign req_r   = right_sync_q & ~left_sync_q;
    assign any_req = hz | req_l | req_r;
    assign tick    = (cnt_q == CNT_LAST);

    // Prescaler parks at zero while idle so the first lamp always lands a full step after a request.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if ((state_q == IDLE) && !any_req) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (req_l)      state_d = L1;
                    else if (req_r) state_d = R1;
                end
                L1:      state_d = req_l ? L2 : IDLE;
                L2:      state_d = req_l ? L3 : IDLE;
                L3:      state_d = IDLE;
                R1:      state_d = req_r ? R2 : IDLE;
                R2:      state_d = req_r ? R3 : IDLE;
                R3:      state_d = IDLE;
`ifdef HAZARD_EN
                HZ_ON:   state_d = hz ? HZ_OFF : IDLE;
                HZ_OFF:  state_d = hz ? HZ_ON : IDLE;
`endif
                default: state_d = IDLE;
            endcase
`ifdef HAZARD_EN
            if (hz && (state_q != HZ_ON) && (state_q != HZ_OFF)) begin
                state_d = HZ_ON;
            end
`endif
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        seg_code_d    = 3'b000;
        left_lamps_d  = 3'b000;
        right_lamps_d = 3'b000;
        busy_d        = (state_d != IDLE);
        case (state_d)
            L1: begin seg_code_d = 3'b001; left_lamps_d  = 3'b001; end
            L2: begin seg_code_d = 3'b001; left_lamps_d  = 3'b011; end
            L3: begin seg_code_d = 3'b001; left_lamps_d  = 3'b111; end
            R1: begin seg_code_d = 3'b011; right_lamps_d = 3'b001; end
            R2: begin seg_code_d = 3'b011; right_lamps_d = 3'b011; end
            R3: begin seg_code_d = 3'b011; right_lamps_d = 3'b111; end
`ifdef HAZARD_EN
            HZ_ON: begin
                left_lamps_d  = 3'b111;
                right_lamps_d = 3'b111;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            seg_code_q    <= 3'b000;
            left_lamps_q  <= 3'b000;
            right_lamps_q <= 3'b000;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            seg_code_q    <= seg_code_d;
            left_lamps_q  <= left_lamps_d;
            right_lamps_q <= right_lamps_d;
            busy_q        <= busy_d;
        end
    end

    assign sig.seg_code    = seg_code_q;
    assign sig.left_lamps  = left_lamps_q;
    assign sig.right_lamps = right_lamps_q;
    assign sig.busy        = busy_q;

endmodule

// File: tb/tb_turn_signal_seq.sv
// Directed testbench for turn_signal_seq with TICK_DIV=4; hazard cases follow HAZARD_EN.
module tb_turn_signal_seq;

    logic clk;
    logic rst_n;
    int   check_count;
    int   fail_count;

    turn_signal_seq_if sig_if ();

    turn_signal_seq #(.TICK_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (sig_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic l, input logic r, input logic h);
        sig_if.left_sw   = l;
        sig_if.right_sw  = r;
        sig_if.hazard_sw = h;
    endtask

    task automatic checkOutput(input string tag, input logic [9:0] observed, input logic [9:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got seg/left/right/busy=%b expected %b", tag, observed, expected);
        end
    endtask

    task automatic expectOutputs(input string tag, input logic [2:0] seg, input logic [2:0] l,
                                 input logic [2:0] r, input logic b);
        checkOutput(tag, {sig_if.seg_code, sig_if.left_lamps, sig_if.right_lamps, sig_if.busy},
                    {seg, l, r, b});
    endtask

    // Advance n rising edges, then settle just after the last one.
    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doReset(input string tag);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        stepCycles(3);
        expectOutputs(tag, 3'b000, 3'b000, 3'b000, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        check_count = 0;
        fail_count  = 0;
        rst_n       = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Left held: pattern 001,011,111,000 stepping every 4 cycles, first lamp 6 edges in.
        doReset("reset_left");
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepCycles(5);
        expectOutputs("left_pre", 3'b000, 3'b000, 3'b000, 1'b0);
        stepCycles(1);
        expectOutputs("left_l1", 3'b001, 3'b001, 3'b000, 1'b1);
        stepCycles(3);
        expectOutputs("left_l1_hold", 3'b001, 3'b001, 3'b000, 1'b1);
        stepCycles(1);
        expectOutputs("left_l2", 3'b001, 3'b011, 3'b000, 1'b1);
        stepCycles(4);
        expectOutputs("left_l3", 3'b001, 3'b111, 3'b000, 1'b1);
        stepCycles(4);
        expectOutputs("left_blank", 3'b000, 3'b000, 3'b000, 1'b0);
        stepCycles(4);
        expectOutputs("left_l1_again", 3'b001, 3'b001, 3'b000, 1'b1);
        stepCycles(4);
        expectOutputs("left_l2_again", 3'b001, 3'b011, 3'b000, 1'b1);

        // Asynchronous reset in the middle of L2 clears outputs before the next edge.
        stepCycles(1);
        rst_n = 1'b0;
        #1;
        expectOutputs("reset_async", 3'b000, 3'b000, 3'b000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        stepCycles(2);
        rst_n = 1'b1;

        // Right held, dropped during R2: next tick returns to idle.
        doReset("reset_right");
        applyStimulus(1'b0, 1'b1, 1'b0);
        stepCycles(6);
        expectOutputs("right_r1", 3'b011, 3'b000, 3'b001, 1'b1);
        stepCycles(4);
        expectOutputs("right_r2", 3'b011, 3'b000, 3'b011, 1'b1);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        stepCycles(2);
        expectOutputs("right_r2_late", 3'b011, 3'b000, 3'b011, 1'b1);
        stepCycles(1);
        expectOutputs("right_drop_idle", 3'b000, 3'b000, 3'b000, 1'b0);
        stepCycles(8);
        expectOutputs("right_stay_idle", 3'b000, 3'b000, 3'b000, 1'b0);

        // Both directions: no request for 40 cycles, and the prescaler stays parked.
        doReset("reset_both");
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            stepCycles(4);
            expectOutputs("both_idle", 3'b000, 3'b000, 3'b000, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepCycles(5);
        expectOutputs("both_release_pre", 3'b000, 3'b000, 3'b000, 1'b0);
        stepCycles(1);
        expectOutputs("both_release_l1", 3'b001, 3'b001, 3'b000, 1'b1);

`ifdef HAZARD_EN
        // Hazard raised during L2: flashing 111/000 on both sides, code 000.
        doReset("reset_hazard");
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepCycles(10);
        expectOutputs("hazard_l2", 3'b001, 3'b011, 3'b000, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        stepCycles(4);
        expectOutputs("hazard_on", 3'b000, 3'b111, 3'b111, 1'b1);
        stepCycles(4);
        expectOutputs("hazard_off", 3'b000, 3'b000, 3'b000, 1'b1);
        stepCycles(4);
        expectOutputs("hazard_on_again", 3'b000, 3'b111, 3'b111, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepCycles(4);
        expectOutputs("hazard_drop_idle", 3'b000, 3'b000, 3'b000, 1'b0);
`else
        // Without the hazard option the hazard switch changes nothing.
        doReset("reset_hazard");
        applyStimulus(1'b1, 1'b0, 1'b1);
        stepCycles(6);
        expectOutputs("nohazard_l1", 3'b001, 3'b001, 3'b000, 1'b1);
        stepCycles(8);
        expectOutputs("nohazard_l3", 3'b001, 3'b111, 3'b000, 1'b1);
        stepCycles(4);
        expectOutputs("nohazard_blank", 3'b000, 3'b000, 3'b000, 1'b0);
`endif

        // Left to right swap goes through idle before R1.
        doReset("reset_swap");
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepCycles(6);
        expectOutputs("swap_l1", 3'b001, 3'b001, 3'b000, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        stepCycles(4);
        expectOutputs("swap_idle", 3'b000, 3'b000, 3'b000, 1'b0);
        stepCycles(4);
        expectOutputs("swap_r1", 3'b011, 3'b000, 3'b001, 1'b1);

        // One-cycle dropout of left between ticks is not seen at the tick.
        doReset("reset_glitch");
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepCycles(6);
        expectOutputs("glitch_l1", 3'b001, 3'b001, 3'b000, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        stepCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        stepCycles(3);
        expectOutputs("glitch_l2", 3'b001, 3'b011, 3'b000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
